// File: rtl/prover_compute_v_round_pkg.sv
// Shared field definitions and FSM state encoding for the V-array round collapse.
// The field is GF(p) with the Mersenne prime p = 2^61 - 1, so reduction is a fold.
package prover_compute_v_round_pkg;

  localparam int F_NBITS = 61;
  localparam logic [F_NBITS-1:0] F_PRIME = 61'h1FFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_CAPT = 3'd3,
    ST_COMP = 3'd4,
    ST_WR   = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  // Modular multiply of two reduced operands: fold the high half onto the low half.
  function automatic logic [F_NBITS-1:0] mul_mod(input logic [F_NBITS-1:0] a,
                                                 input logic [F_NBITS-1:0] b);
    logic [2*F_NBITS-1:0] prod;
    logic [F_NBITS:0]     s;
    logic [F_NBITS:0]     t;
    prod = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
    s = {1'b0, prod[F_NBITS-1:0]} + {1'b0, prod[2*F_NBITS-1:F_NBITS]};
    t = {1'b0, s[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, s[F_NBITS]};
    if (t >= {1'b0, F_PRIME}) t = t - {1'b0, F_PRIME};
    return t[F_NBITS-1:0];
  endfunction

  // Modular add of two reduced operands.
  function automatic logic [F_NBITS-1:0] add_mod(input logic [F_NBITS-1:0] a,
                                                 input logic [F_NBITS-1:0] b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_PRIME}) s = s - {1'b0, F_PRIME};
    return s[F_NBITS-1:0];
  endfunction

endpackage

// File: rtl/prover_compute_v_elem.sv
// Computes vtau = (1-tau)*v0 + tau*v1 mod p for one pair.
// Two-stage pipeline: products on the cycle after en, sum one cycle later with ready_pulse.
module prover_compute_v_elem
  import prover_compute_v_round_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] tau,
  input  logic [F_NBITS-1:0] m_tau_p1,
  input  logic [F_NBITS-1:0] v0,
  input  logic [F_NBITS-1:0] v1,
  output logic [F_NBITS-1:0] vtau,
  output logic               ready_pulse
);

  logic [F_NBITS-1:0] p0_q, p0_d;
  logic [F_NBITS-1:0] p1_q, p1_d;
  logic [F_NBITS-1:0] vtau_q, vtau_d;
  logic               s1_valid_q, s1_valid_d;
  logic               ready_pulse_q, ready_pulse_d;

  // Next-state for the multiply stage and the add stage.
  always_comb begin
    p0_d          = p0_q;
    p1_d          = p1_q;
    vtau_d        = vtau_q;
    s1_valid_d    = en;
    ready_pulse_d = s1_valid_q;
    if (en) begin
      p0_d = mul_mod(m_tau_p1, v0);
      p1_d = mul_mod(tau, v1);
    end
    if (s1_valid_q) begin
      vtau_d = add_mod(p0_q, p1_q);
    end
  end

  // Pipeline registers; cleared immediately on reset so no stale pulse escapes.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      p0_q          <= '0;
      p1_q          <= '0;
      vtau_q        <= '0;
      s1_valid_q    <= 1'b0;
      ready_pulse_q <= 1'b0;
    end else begin
      p0_q          <= p0_d;
      p1_q          <= p1_d;
      vtau_q        <= vtau_d;
      s1_valid_q    <= s1_valid_d;
      ready_pulse_q <= ready_pulse_d;
    end
  end

  assign vtau        = vtau_q;
  assign ready_pulse = ready_pulse_q;

endmodule

// File: rtl/prover_compute_v_round.sv
// Collapses the V array in RAM by one sumcheck round: V'[j] = (1-tau)V[2j] + tau V[2j+1].
// Results are written in place at j; the write to j always trails the reads of 2j/2j+1.
module prover_compute_v_round
  import prover_compute_v_round_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 en,
  input  logic [F_NBITS-1:0]   tau,
  input  logic [F_NBITS-1:0]   m_tau_p1,
  input  logic [ADDR_BITS:0]   n_in,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [F_NBITS-1:0]   rd_data,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [F_NBITS-1:0]   wr_data,
  output logic [ADDR_BITS:0]   n_out,
  output logic                 ready,
  output logic                 ready_pulse
);

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   j_q, j_d;
  logic [ADDR_BITS:0]     n_out_q, n_out_d;
  logic                   n_odd_q, n_odd_d;
  logic [F_NBITS-1:0]     tau_q, tau_d;
  logic [F_NBITS-1:0]     m_q, m_d;
  logic [F_NBITS-1:0]     v0_q, v0_d;
  logic [F_NBITS-1:0]     v1_q, v1_d;
  logic [ADDR_BITS-1:0]   rd_addr_q;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [F_NBITS-1:0]     wr_data_q, wr_data_d;
  logic                   elem_en_q, elem_en_d;
  logic [F_NBITS-1:0]     elem_vtau;
  logic                   elem_ready_pulse;
  logic [ADDR_BITS:0]     j_inc;
  logic [ADDR_BITS+1:0]   n_sum;
  logic                   last_pair;

  assign j_inc     = {1'b0, j_q} + {{ADDR_BITS{1'b0}}, 1'b1};
  assign n_sum     = {1'b0, n_in} + {{(ADDR_BITS+1){1'b0}}, 1'b1};
  assign last_pair = (j_inc == n_out_q);

  // Read address is driven from the state so it appears in RD0/RD1 and holds otherwise.
  always_comb begin
    rd_addr = rd_addr_q;
    if (state_q == ST_RD0) rd_addr = {j_q[ADDR_BITS-2:0], 1'b0};
    if (state_q == ST_RD1) rd_addr = {j_q[ADDR_BITS-2:0], 1'b1};
  end

  // Next-state and datapath control for the per-pair read/compute/write sequence.
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    n_out_d   = n_out_q;
    n_odd_d   = n_odd_q;
    tau_d     = tau_q;
    m_d       = m_q;
    v0_d      = v0_q;
    v1_d      = v1_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    elem_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          tau_d   = tau;
          m_d     = m_tau_p1;
          n_odd_d = n_in[0];
          n_out_d = n_sum[ADDR_BITS+1:1];
          j_d     = '0;
          state_d = (n_in == '0) ? ST_DONE : ST_RD0;
        end
      end
      ST_RD0: state_d = ST_RD1;
      ST_RD1: begin
        v0_d    = rd_data;
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        v1_d      = (n_odd_q && last_pair) ? '0 : rd_data;
        elem_en_d = 1'b1;
        state_d   = ST_COMP;
      end
      ST_COMP: begin
        if (elem_ready_pulse) begin
          wr_en_d   = 1'b1;
          wr_addr_d = j_q;
          wr_data_d = elem_vtau;
          state_d   = ST_WR;
        end
      end
      ST_WR: begin
        j_d     = j_inc[ADDR_BITS-1:0];
        state_d = last_pair ? ST_DONE : ST_RD0;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset returns to IDLE with all outputs quiet.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      j_q       <= '0;
      n_out_q   <= '0;
      n_odd_q   <= 1'b0;
      tau_q     <= '0;
      m_q       <= '0;
      v0_q      <= '0;
      v1_q      <= '0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      elem_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      n_out_q   <= n_out_d;
      n_odd_q   <= n_odd_d;
      tau_q     <= tau_d;
      m_q       <= m_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      rd_addr_q <= rd_addr;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      elem_en_q <= elem_en_d;
    end
  end

  prover_compute_v_elem u_elem (
    .clk         (clk),
    .rstb        (rstb),
    .en          (elem_en_q),
    .tau         (tau_q),
    .m_tau_p1    (m_q),
    .v0          (v0_q),
    .v1          (v1_q),
    .vtau        (elem_vtau),
    .ready_pulse (elem_ready_pulse)
  );

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign n_out       = n_out_q;
  assign ready       = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign ready_pulse = (state_q == ST_DONE);

endmodule
